obuf: RTL and testbench

Output buffer for the crossbar datapath: captures one full parallel vector of `fifo_length` elements in a single cycle and streams it out one element per transfer over a valid/ready interface. It is the drain-side counterpart of `ibuf`, which fills a vector serially. `obuf` sits after the crossbar/ADC result stage and feeds the serial result stream toward the host or the next layer's `ibuf`. It emits elements highest index first, so feeding its stream straight into an `ibuf` of equal length reproduces the original vector layout.

---
 rtl/obuf.sv | 75 +++++++
 tb/tb_obuf.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/obuf.sv
// Parallel-to-serial output buffer: captures a whole vector in one cycle and
// streams it out highest index first over a valid/ready handshake.
module obuf #(
  parameter int datatype_size = 8,
  parameter int fifo_length   = 720
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_load,
  input  logic [datatype_size-1:0] i_data [fifo_length-1:0],
  output logic                     o_ready_load,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [datatype_size-1:0] o_data,
  output logic                     o_last
);

  localparam int IW = $clog2(fifo_length);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                   state_q, state_d;
  logic [IW-1:0]            idx_q, idx_d;
  logic [datatype_size-1:0] buf_q [fifo_length-1:0];
  logic                     load_en;
  logic                     xfer;

  assign load_en = (state_q == IDLE) && i_load;
  assign xfer    = (state_q == SEND) && i_ready;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    o_ready_load = 1'b0;
    o_valid      = 1'b0;
    o_last       = 1'b0;
    o_data       = '0;
    case (state_q)
      IDLE: begin
        o_ready_load = 1'b1;
        if (i_load) begin
          idx_d   = IW'(fifo_length - 1);
          state_d = SEND;
        end
      end
      SEND: begin
        o_valid = 1'b1;
        o_data  = buf_q[idx_q];
        o_last  = (idx_q == '0);
        // The final element returns to IDLE, so idx never wraps below zero.
        if (xfer) begin
          if (idx_q == '0) state_d = IDLE;
          else             idx_d   = idx_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Vector storage carries no reset; it is only read while in SEND.
  always_ff @(posedge clk) begin
    if (load_en) buf_q <= i_data;
  end

endmodule

// File: tb/tb_obuf.sv
// Directed bench for obuf (fifo_length=4, datatype_size=8) with a shift-in
// collector standing in for a downstream ibuf.
module tb_obuf;

  localparam int DW = 8;
  localparam int FL = 4;

  logic          clk, rst, i_load, i_ready;
  logic [DW-1:0] i_data [FL-1:0];
  logic          o_ready_load, o_valid, o_last;
  logic [DW-1:0] o_data;

  logic [DW-1:0] va [FL-1:0];
  logic [DW-1:0] vb [FL-1:0];
  logic [DW-1:0] vc [FL-1:0];
  logic [DW-1:0] vf [FL-1:0];
  logic [DW-1:0] vx [FL-1:0];
  logic [DW-1:0] sr [FL-1:0];

  int vecs = 0;
  int errs = 0;

  obuf #(.datatype_size(DW), .fifo_length(FL)) dut (
    .clk(clk), .rst(rst), .i_load(i_load), .i_data(i_data),
    .o_ready_load(o_ready_load), .o_valid(o_valid), .i_ready(i_ready),
    .o_data(o_data), .o_last(o_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_elem(input string tag, input logic [DW-1:0] d, input logic last);
    chk({tag, "_valid"}, 32'(o_valid), 32'd1);
    chk({tag, "_data"},  32'(o_data),  32'(d));
    chk({tag, "_last"},  32'(o_last),  32'(last));
    chk({tag, "_rdy"},   32'(o_ready_load), 32'd0);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, 32'(o_valid), 32'd0);
    chk({tag, "_data"},  32'(o_data),  32'd0);
    chk({tag, "_last"},  32'(o_last),  32'd0);
    chk({tag, "_rdy"},   32'(o_ready_load), 32'd1);
  endtask

  initial begin
    va = '{8'h0D, 8'h0C, 8'h0B, 8'h0A};
    vb = '{8'h14, 8'h13, 8'h12, 8'h11};
    vc = '{8'h5A, 8'hA5, 8'h3C, 8'hC3};
    vf = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
    rst = 1'b1; i_load = 1'b0; i_ready = 1'b0; i_data = va;
    step; step;
    rst = 1'b0;
    chk_idle("reset");

    // Basic drain
    i_data = va; i_load = 1'b1; i_ready = 1'b1;
    step;
    i_load = 1'b0;
    for (int k = FL - 1; k >= 0; k--) begin
      chk_elem($sformatf("basic%0d", k), va[k], k == 0);
      step;
    end
    chk_idle("basic_end");

    // Backpressure after the first transfer
    i_load = 1'b1;
    step;
    i_load = 1'b0;
    chk_elem("bp3", 8'h0D, 1'b0);
    step;
    i_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      chk_elem($sformatf("bp_stall%0d", s), 8'h0C, 1'b0);
      step;
    end
    i_ready = 1'b1;
    for (int k = FL - 2; k >= 0; k--) begin
      chk_elem($sformatf("bp%0d", k), va[k], k == 0);
      step;
    end
    chk_idle("bp_end");

    // Load while busy, including on the final-transfer cycle
    i_data = va; i_load = 1'b1;
    step;
    i_data = vf;
    for (int k = FL - 1; k >= 0; k--) begin
      chk_elem($sformatf("busy%0d", k), va[k], k == 0);
      step;
    end
    i_load = 1'b0;
    chk_idle("busy_end");
    step;
    chk_idle("busy_idle2");

    // Back-to-back with i_load held high; alternating vectors, period 5
    i_load = 1'b1;
    for (int v = 0; v < 3; v++) begin
      vx = (v % 2 == 0) ? va : vb;
      i_data = vx;
      step;
      i_data = (v % 2 == 0) ? vb : va;
      for (int k = FL - 1; k >= 0; k--) begin
        chk_elem($sformatf("b2b%0d_%0d", v, k), vx[k], k == 0);
        step;
      end
      chk_idle($sformatf("b2b%0d_gap", v));
    end
    i_load = 1'b0;

    // Reset after two transfers
    i_data = va; i_load = 1'b1;
    step;
    i_load = 1'b0;
    chk_elem("rm3", 8'h0D, 1'b0);
    step;
    chk_elem("rm2", 8'h0C, 1'b0);
    step;
    rst = 1'b1;
    step;
    rst = 1'b0;
    chk_idle("rm_after");
    i_data = vb; i_load = 1'b1;
    step;
    i_load = 1'b0;
    for (int k = FL - 1; k >= 0; k--) begin
      chk_elem($sformatf("rm_fresh%0d", k), vb[k], k == 0);
      step;
    end
    chk_idle("rm_fresh_end");

    // Loopback into an ibuf-style shift-in collector with random ready
    begin
      int n;
      bit done, stalled;
      logic [DW-1:0] prev;
      n = 0; done = 1'b0; stalled = 1'b0; prev = '0;
      for (int i = 0; i < FL; i++) sr[i] = '0;
      i_data = vc; i_load = 1'b1; i_ready = 1'b0;
      step;
      i_load = 1'b0; i_data = vf;
      for (int cyc = 0; cyc < 200 && !done; cyc++) begin
        i_ready = 1'($urandom_range(0, 1));
        #1;
        if (stalled) chk($sformatf("lb_hold%0d", cyc), 32'(o_data), 32'(prev));
        if (o_valid && i_ready) begin
          for (int i = FL - 1; i > 0; i--) sr[i] = sr[i-1];
          sr[0] = o_data;
          n++;
          if (o_last) done = 1'b1;
        end
        stalled = o_valid && !i_ready;
        prev = o_data;
        @(posedge clk);
        #1;
      end
      chk("lb_done", 32'(done), 32'd1);
      chk("lb_count", 32'(n), 32'(FL));
      for (int i = 0; i < FL; i++) chk($sformatf("lb_elem%0d", i), 32'(sr[i]), 32'(vc[i]));
      chk_idle("lb_end");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
